// File: rtl/adat_encoder.sv
// ADAT lightpipe frame encoder: 8 x 24-bit channels plus 4 user bits, NRZI-coded, one bit per clock.
// Samples are staged, then copied to a shadow buffer at frame start so the serializer sees a stable frame.
module adat_encoder (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        sample_we_i,
    input  logic [2:0]  sample_chan_i,
    input  logic [23:0] sample_data_i,
    input  logic [3:0]  user_bits_i,
    output logic        adat_o,
    output logic        frame_start_o,
    output logic        underrun_o,
    output logic        busy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [7:0]  r_bit_cnt;
    logic [2:0]  r_grp_pos;
    logic [2:0]  r_nib;
    logic [2:0]  r_chan;
    logic [23:0] r_staging [8];
    logic [23:0] r_shadow  [8];
    logic [3:0]  r_user;
    logic [7:0]  r_written;
    logic        r_adat;
    logic        r_underrun;

    logic        w_run;
    logic        w_load;
    logic        w_bit;
    logic [4:0]  w_data_idx;
    logic [1:0]  w_user_sel;
    logic [7:0]  w_write_mask;

    assign w_run        = (r_state == ST_RUN);
    assign w_load       = w_run && (r_bit_cnt == 8'd0);
    assign w_user_sel   = ~r_bit_cnt[1:0];
    assign w_data_idx   = 5'd24 - {r_nib, 2'b00} - {2'b00, r_grp_pos};
    assign w_write_mask = sample_we_i ? (8'h01 << sample_chan_i) : 8'h00;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= 8'd0;
                    if (enable_i) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    // 8-bit counter wraps 255 -> 0, so back-to-back frames have no gap
                    r_bit_cnt <= r_bit_cnt + 8'd1;
                    if ((r_bit_cnt == 8'd255) && !enable_i) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Channel / nibble / bit-in-group position for the 240 data-region bits, starting at index 16
    always_ff @(posedge clk_i) begin
        if (reset_i || !w_run || (r_bit_cnt == 8'd15)) begin
            r_grp_pos <= 3'd0;
            r_nib     <= 3'd0;
            r_chan    <= 3'd0;
        end else if (r_bit_cnt >= 8'd16) begin
            if (r_grp_pos == 3'd4) begin
                r_grp_pos <= 3'd0;
                if (r_nib == 3'd5) begin
                    r_nib  <= 3'd0;
                    r_chan <= r_chan + 3'd1;
                end else begin
                    r_nib <= r_nib + 3'd1;
                end
            end else begin
                r_grp_pos <= r_grp_pos + 3'd1;
            end
        end
    end

    always_comb begin
        w_bit = 1'b0;
        if (r_bit_cnt >= 8'd16) begin
            if (r_grp_pos == 3'd0) begin
                w_bit = 1'b1;
            end else begin
                w_bit = r_shadow[r_chan][w_data_idx];
            end
        end else if ((r_bit_cnt == 8'd0) || (r_bit_cnt == 8'd11)) begin
            w_bit = 1'b1;
        end else if (r_bit_cnt >= 8'd12) begin
            w_bit = r_user[w_user_sel];
        end
    end

    // A write landing on the load cycle reaches staging only, so the shadow keeps the old value
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 8; i++) begin
                r_staging[i] <= 24'd0;
                r_shadow[i]  <= 24'd0;
            end
            r_user    <= 4'd0;
            r_written <= 8'd0;
        end else begin
            if (w_load) begin
                for (int i = 0; i < 8; i++) begin
                    r_shadow[i] <= r_staging[i];
                end
                r_user <= user_bits_i;
            end
            if (sample_we_i) begin
                r_staging[sample_chan_i] <= sample_data_i;
            end
            r_written <= (w_load ? 8'h00 : r_written) | w_write_mask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_adat     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_run) begin
                r_adat <= r_adat ^ w_bit;
            end
            r_underrun <= w_load && (r_written != 8'hFF);
        end
    end

    assign adat_o        = r_adat;
    assign frame_start_o = w_load;
    assign underrun_o    = r_underrun;
    assign busy_o        = w_run;

endmodule
